// File: rtl/accumulator_decimator_if.sv
// Output side of the decimator: one block average per transfer, with its clip flag.
// A transfer completes at a rising edge where out_valid && out_ready are both high;
// the producer holds out_data/sat stable and out_valid high until then, and the
// consumer's out_ready has no meaning while out_valid is low.
interface accumulator_decimator_if #(
  parameter int OUT_W = 13
);
  logic signed [OUT_W-1:0] out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    sat;

  modport master (output out_data, output out_valid, output sat, input out_ready);
  modport slave  (input out_data, input out_valid, input sat, output out_ready);
endinterface

// File: rtl/accumulator_decimator.sv
// Integrate-and-dump stage: differences the accumulator's running sum every 2^LOG2_N
// ce samples, rounds/saturates the block average to OUT_W bits and hands it downstream.
module accumulator_decimator #(
  parameter int IN_W   = 21,
  parameter int OUT_W  = 13,
  parameter int LOG2_N = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic signed [IN_W-1:0] sum_in,
  accumulator_decimator_if.master out_if,
  output logic                   overrun
);

  localparam logic [LOG2_N-1:0]  LAST  = '1;
  localparam logic signed [IN_W:0] HALF  = (IN_W+1)'(1 << (LOG2_N-1));
  localparam logic signed [IN_W:0] MAX_V = (IN_W+1)'((1 << (OUT_W-1)) - 1);
  localparam logic signed [IN_W:0] MIN_V = ~MAX_V;

  logic [LOG2_N-1:0]      cnt;
  logic signed [IN_W-1:0] snap;
  logic signed [IN_W-1:0] diff;
  logic                   v1;
  logic                   dump;

  logic signed [IN_W:0]   rnd;
  logic signed [IN_W:0]   sh;
  logic signed [OUT_W-1:0] avg_clip;
  logic                   avg_sat;
  logic                   load;

  assign dump = ce && (cnt == LAST);

  // Stage 1: modular difference, so an accumulator wrap inside a block is harmless.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt  <= '0;
      snap <= '0;
      diff <= '0;
      v1   <= 1'b0;
    end else begin
      v1 <= dump;
      if (ce) begin
        cnt <= cnt + 1'b1;
      end
      if (dump) begin
        diff <= sum_in - snap;
        snap <= sum_in;
      end
    end
  end

  // Stage 2: one extra bit keeps the rounding add from wrapping.
  always_comb begin
    rnd      = {diff[IN_W-1], diff} + HALF;
    sh       = rnd >>> LOG2_N;
    avg_sat  = 1'b0;
    avg_clip = sh[OUT_W-1:0];
    if (sh > MAX_V) begin
      avg_clip = MAX_V[OUT_W-1:0];
      avg_sat  = 1'b1;
    end else if (sh < MIN_V) begin
      avg_clip = MIN_V[OUT_W-1:0];
      avg_sat  = 1'b1;
    end
  end

  assign load = v1 && (!out_if.out_valid || out_if.out_ready);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_if.out_data  <= '0;
      out_if.out_valid <= 1'b0;
      out_if.sat       <= 1'b0;
      overrun          <= 1'b0;
    end else begin
      if (load) begin
        out_if.out_data  <= avg_clip;
        out_if.sat       <= avg_sat;
        out_if.out_valid <= 1'b1;
      end else if (v1) begin
        // Register full and not draining: keep the held result, drop the new one.
        overrun <= 1'b1;
      end else if (out_if.out_valid && out_if.out_ready) begin
        out_if.out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_accumulator_decimator.sv
// Directed bench for accumulator_decimator: table of block sums plus hand-written
// sequences for ramp, backpressure, mid-block reset and ce gaps.
module tb_accumulator_decimator;

  logic                 clk;
  logic                 rst;
  logic                 ce;
  logic signed [20:0]   sum_in;
  logic                 overrun;

  accumulator_decimator_if #(.OUT_W(13)) dif ();

  accumulator_decimator #(.IN_W(21), .OUT_W(13), .LOG2_N(3)) dut (
    .clk     (clk),
    .rst     (rst),
    .ce      (ce),
    .sum_in  (sum_in),
    .out_if  (dif),
    .overrun (overrun)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [12:0] exp_q[$];

  typedef struct {
    logic signed [20:0] final_sum;
    logic [12:0]        exp_data;
    logic               exp_sat;
  } vec_t;

  vec_t vecs[9];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Seven don't-care samples, then the block-ending sample; ce drops afterwards.
  task automatic block_to(input logic signed [20:0] final_sum);
    for (int j = 0; j < 7; j++) begin
      ce = 1'b1;
      sum_in = 21'($urandom);
      tick();
    end
    sum_in = final_sum;
    tick();
    ce = 1'b0;
  endtask

  task automatic pulse_reset();
    rst = 1'b0;
    #3;
    check("rst_data", {19'b0, dif.out_data}, 32'h0);
    check("rst_valid", {31'b0, dif.out_valid}, 32'h0);
    check("rst_sat", {31'b0, dif.sat}, 32'h0);
    check("rst_overrun", {31'b0, overrun}, 32'h0);
    rst = 1'b1;
  endtask

  initial begin
    int pulses;
    int first_idx;
    logic signed [20:0] acc;

    vecs[0] = '{21'sd128,      13'h0010, 1'b0};
    vecs[1] = '{21'sd140,      13'h0002, 1'b0};
    vecs[2] = '{21'sd128,      13'h1FFF, 1'b0};
    vecs[3] = '{21'sd132,      13'h0001, 1'b0};
    vecs[4] = '{21'sd40132,    13'h0FFF, 1'b1};
    vecs[5] = '{21'sd132,      13'h1000, 1'b1};
    vecs[6] = '{21'sd1048560,  13'h0FFF, 1'b1};
    vecs[7] = '{-21'sd1048464, 13'h0010, 1'b0};
    vecs[8] = '{21'sd1048432,  13'h1FE0, 1'b0};

    rst = 1'b0;
    ce = 1'b0;
    sum_in = '0;
    dif.out_ready = 1'b0;
    repeat (3) tick();
    check("por_valid", {31'b0, dif.out_valid}, 32'h0);
    check("por_data", {19'b0, dif.out_data}, 32'h0);
    check("por_overrun", {31'b0, overrun}, 32'h0);
    rst = 1'b1;
    tick();

    // Ramp: constant 1.0 input, ready held high.
    dif.out_ready = 1'b1;
    pulses = 0;
    first_idx = 0;
    repeat (3) exp_q.push_back(13'h0010);
    for (int i = 1; i <= 26; i++) begin
      ce = (i <= 24);
      if (i <= 24) sum_in = 21'(16 * i);
      tick();
      if (dif.out_valid) begin
        pulses++;
        if (first_idx == 0) first_idx = i;
        if (exp_q.size() == 0) begin
          check("ramp_extra", 32'h1, 32'h0);
        end else begin
          check("ramp_data", {19'b0, dif.out_data}, {19'b0, exp_q.pop_front()});
          check("ramp_sat", {31'b0, dif.sat}, 32'h0);
        end
      end
    end
    ce = 1'b0;
    check("ramp_pulses", pulses, 3);
    check("ramp_first_edge", first_idx, 9);
    check("ramp_q_empty", exp_q.size(), 0);

    // Table: each entry is a block ending at final_sum; snap starts at 0 after reset.
    tick();
    pulse_reset();
    tick();
    for (int v = 0; v < 9; v++) begin
      block_to(vecs[v].final_sum);
      check($sformatf("v%0d_latency", v), {31'b0, dif.out_valid}, 32'h0);
      tick();
      check($sformatf("v%0d_valid", v), {31'b0, dif.out_valid}, 32'h1);
      check($sformatf("v%0d_data", v), {19'b0, dif.out_data}, {19'b0, vecs[v].exp_data});
      check($sformatf("v%0d_sat", v), {31'b0, dif.sat}, {31'b0, vecs[v].exp_sat});
      tick();
      check($sformatf("v%0d_drain", v), {31'b0, dif.out_valid}, 32'h0);
    end
    check("tbl_overrun", {31'b0, overrun}, 32'h0);

    // Backpressure: two results (16 then 32) with ready low.
    acc = 21'sd1048432;
    dif.out_ready = 1'b0;
    acc = acc + 21'sd128;
    block_to(acc);
    tick();
    check("bp_first_valid", {31'b0, dif.out_valid}, 32'h1);
    check("bp_first_data", {19'b0, dif.out_data}, 32'h10);
    acc = acc + 21'sd256;
    block_to(acc);
    tick();
    check("bp_hold_data", {19'b0, dif.out_data}, 32'h10);
    check("bp_hold_valid", {31'b0, dif.out_valid}, 32'h1);
    check("bp_overrun", {31'b0, overrun}, 32'h1);
    dif.out_ready = 1'b1;
    tick();
    check("bp_accept_valid", {31'b0, dif.out_valid}, 32'h0);
    check("bp_accept_data", {19'b0, dif.out_data}, 32'h10);
    check("bp_sticky", {31'b0, overrun}, 32'h1);

    // Accept and reload at the same edge.
    tick();
    pulse_reset();
    dif.out_ready = 1'b0;
    tick();
    block_to(21'sd128);
    tick();
    check("same_first", {19'b0, dif.out_data}, 32'h10);
    block_to(21'sd512);
    dif.out_ready = 1'b1;
    tick();
    check("same_valid", {31'b0, dif.out_valid}, 32'h1);
    check("same_data", {19'b0, dif.out_data}, 32'h30);
    check("same_no_overrun", {31'b0, overrun}, 32'h0);
    tick();
    check("same_drain", {31'b0, dif.out_valid}, 32'h0);

    // Mid-block reset with a held result and overrun pending.
    dif.out_ready = 1'b0;
    block_to(21'sd640);
    tick();
    block_to(21'sd768);
    tick();
    check("pre_rst_overrun", {31'b0, overrun}, 32'h1);
    for (int i = 1; i <= 5; i++) begin
      ce = 1'b1;
      sum_in = 21'(768 + 16 * i);
      tick();
    end
    ce = 1'b0;
    #1;
    pulse_reset();

    // Fresh block after reset, with a 10-cycle ce gap after sample 4.
    dif.out_ready = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 8; i++) begin
      ce = 1'b1;
      sum_in = 21'(16 * i);
      tick();
      if (dif.out_valid) pulses++;
      if (i == 4) begin
        ce = 1'b0;
        repeat (10) begin
          tick();
          if (dif.out_valid) pulses++;
        end
      end
    end
    ce = 1'b0;
    check("fresh_no_early", pulses, 0);
    tick();
    check("fresh_valid", {31'b0, dif.out_valid}, 32'h1);
    check("fresh_data", {19'b0, dif.out_data}, 32'h10);
    check("fresh_sat", {31'b0, dif.sat}, 32'h0);
    tick();
    check("fresh_drain", {31'b0, dif.out_valid}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/accumulator_decimator.md
# accumulator_decimator

Integrate-and-dump output stage placed directly downstream of the fixed-point `accumulator`. It consumes the accumulator's running sum on every clock-enabled sample and, once every N samples, emits the block average. The result is rounded and saturated back to the 13-bit Q8.4 input format, and leaves on a valid/ready handshake. Over one block, the running sum is reduced to one averaged sample at rate 1/N.

## Interface
- `IN_W`, 21: running-sum width, signed Q16.4.
- `OUT_W`, 13: output width, signed Q8.4.
- `LOG2_N`, 3: log2 of block length; N = 2^LOG2_N = 8 samples.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset; **asynchronous, active-low**.
- `ce`  in  1  sample strobe, same enable that drives the accumulator.
- `sum_in`  in  IN_W  signed running sum from the accumulator.
- `out_data`  out  OUT_W  signed block average, Q8.4.
- `out_valid`  out  1  `out_data` holds an unaccepted result.
- `out_ready`  in  1  consumer accepts when `out_valid && out_ready` at a rising edge.
- `sat`  out  1  the held result was clipped; qualified by `out_valid`.
- `overrun`  out  1  sticky; a result was dropped under backpressure.

## Operation
- Reset (`rst`=0, asynchronous) clears the following: sample counter `cnt` = 0, snapshot `snap` = 0, pipeline valid = 0, `out_data` = 0, `out_valid` = 0, `sat` = 0, `overrun` = 0.
- Counter behaviour:
  - `cnt` (LOG2_N bits) increments on each edge with `ce`=1.
  - It wraps from N-1 to 0.
  - With `ce`=0, all state holds.
- Dump event: an edge with `ce`=1 and `cnt`=N-1.
  - At that edge: `diff` <= `sum_in` - `snap`, computed modulo 2^IN_W.
  - At that edge: `snap` <= `sum_in`.
  - At that edge: stage-1 valid is set.
- Wrap-around: the subtraction is modular. A wrap of the accumulator inside a block yields the correct difference, provided the true block sum fits IN_W bits.
- First block after reset: `snap`=0, so `diff` = `sum_in`. This is consistent with the accumulator also resetting to 0.
- Stage 2 computes `avg` = (`diff` + 2^(LOG2_N-1)) >>> LOG2_N.
  - The shift is arithmetic.
  - Rounding is round-half-up, toward +inf.
  - The add uses IN_W+1 bits; it does not wrap.
- Saturation: `avg` is clipped to [-2^(OUT_W-1), 2^(OUT_W-1)-1] = [-4096, 4095]. `sat`=1 when clipping occurred.
- Output register loads `avg`/`sat` and sets `out_valid` when the stage-2 result arrives, subject to:
  - If the register is empty, or being accepted at the same edge (`out_valid && out_ready`), the new result loads. No overrun.
  - If the register is full and not accepted, the new result is dropped, the old result is held unchanged, and `overrun` <= 1.
- Acceptance with no new result: `out_valid` <= 0. `out_data` and `sat` keep their last values.
- `overrun` clears only on reset.
- Reset asserted mid-block discards the partial block and any in-flight result. Counting restarts at `cnt`=0 after release.

## Timing
- Latency: the dump edge is k; the result appears on `out_data` with `out_valid`=1 after edge k+1. That is 2 edges from the N-th sample.
- Throughput: at most one result per N `ce` cycles. Because N ≥ 2, the pipeline itself never stalls. Only the output register can overrun.
- `out_valid`, `out_data` and `sat` change only at rising edges, or asynchronously on reset.
- `out_valid` never drops without an accept, except on reset.
- `out_ready` is ignored while `out_valid`=0.
- `ce` gaps stretch the block: N `ce` samples are counted, not N clocks.

## Test plan
- Ramp:
  - Stimulus: `sum_in` increases by 16 per `ce` cycle (constant 1.0 input), `out_ready`=1.
  - Required: `out_data`=16 (0x0010), `sat`=0, one `out_valid` pulse per 8 `ce`.
  - Required: the first result appears 2 edges after the 8th sample.
- Rounding:
  - Stimulus: block differences of +12, then -12.
  - Required: `out_data`=2, then -1 (0x1FFF).
  - Stimulus: difference +4.
  - Required: `out_data`=1.
- Saturation:
  - Stimulus: block difference 40000.
  - Required: `out_data`=4095, `sat`=1.
  - Stimulus: block difference -40000.
  - Required: `out_data`=-4096, `sat`=1.
- Wrap-around:
  - Stimulus: `snap`=1048560, next dump `sum_in`=-1048464.
  - Required: `out_data`=16, `sat`=0.
- Backpressure:
  - Stimulus: `out_ready`=0 across two dumps with averages 16, then 32.
  - Required: `out_data` holds 16, `overrun`=1.
  - Stimulus: raise `out_ready`.
  - Required: 16 is accepted, then `out_valid`=0. `overrun` stays 1.
  - Stimulus: `out_ready`=1 at the same edge a new result arrives.
  - Required: the new value loads, no overrun.
- Reset and `ce` gaps:
  - Stimulus: assert `rst`=0 between edges after 5 samples.
  - Required: all outputs are 0 immediately. After release, the next result needs 8 fresh `ce` samples.
  - Stimulus: `ce`=0 for 10 cycles mid-block.
  - Required: the result is unchanged; only its timing shifts.
